// File: rtl/fake_netlist_bist_ctrl.sv
// Pseudo-random BIST sequencer: LFSR drives the netlist inputs, a 16-bit MISR compacts the
// single netlist output, and the final signature is compared against a golden value.
module fake_netlist_bist_ctrl #(
  parameter int unsigned N_IN     = 13,
  parameter int unsigned PATTERNS = 256,
  parameter int unsigned SETTLE   = 2,
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter logic [15:0] GOLDEN   = 16'h0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            dut_out,
  output logic [N_IN-1:0] dut_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [15:0]     signature,
  output logic [15:0]     pat_cnt
);

  localparam int unsigned SCNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SCNT_W-1:0] SCNT_LOAD = SCNT_W'(SETTLE - 1);
  localparam logic [15:0] LAST_PAT = 16'(PATTERNS - 1);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StSeed    = 3'd1;
  localparam logic [2:0] StSettle  = 3'd2;
  localparam logic [2:0] StCapture = 3'd3;
  localparam logic [2:0] StDone    = 3'd4;

  // Galois form of x^16+x^14+x^13+x^11+1.
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    lfsr_step = (cur >> 1) ^ (cur[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] cur, input logic bit_in);
    misr_step = {cur[14:0], 1'b0} ^ (cur[15] ? 16'h002D : 16'h0000) ^ {15'b0, bit_in};
  endfunction

  logic [2:0]        state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [15:0]       sig_q, sig_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [N_IN-1:0]   din_q, din_d;
  logic [15:0]       lfsr_next;
  logic              go;

  assign lfsr_next = lfsr_step(lfsr_q);
  assign go        = start && !abort;

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    scnt_d  = scnt_q;
    din_d   = din_q;
    // Abort wins over any state action; run state is frozen where it stood.
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (go) state_d = StSeed;
        end
        StSeed: begin
          lfsr_d  = SEED;
          sig_d   = 16'h0000;
          cnt_d   = 16'h0000;
          scnt_d  = SCNT_LOAD;
          din_d   = SEED[N_IN-1:0];
          state_d = StSettle;
        end
        StSettle: begin
          if (scnt_q == '0) begin
            state_d = StCapture;
          end else begin
            scnt_d = scnt_q - SCNT_W'(1);
          end
        end
        StCapture: begin
          sig_d  = misr_step(sig_q, dut_out);
          cnt_d  = cnt_q + 16'd1;
          lfsr_d = lfsr_next;
          din_d  = lfsr_next[N_IN-1:0];
          if (cnt_q == LAST_PAT) begin
            state_d = StDone;
          end else begin
            scnt_d  = SCNT_LOAD;
            state_d = StSettle;
          end
        end
        StDone: begin
          if (go) state_d = StSeed;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      lfsr_q  <= 16'h0000;
      sig_q   <= 16'h0000;
      cnt_q   <= 16'h0000;
      scnt_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      scnt_q  <= scnt_d;
      din_q   <= din_d;
    end
  end

  assign dut_in    = din_q;
  assign signature = sig_q;
  assign pat_cnt   = cnt_q;
  assign busy      = (state_q == StSeed) || (state_q == StSettle) || (state_q == StCapture);
  assign done      = (state_q == StDone);
  assign pass      = done && (sig_q == GOLDEN);

endmodule
